instruction_stepper: RTL and testbench
======================================

INSTRUCTION_STEPPER -- requirements
Module: instruction_stepper

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable clk cycles a button must hold before its level is accepted (10 ms at 100 MHz).
REQ-002 Parameter ADDR_W, default 8, is the instruction-memory word-address width.
REQ-003 Port clk, input, 1, is the 100 MHz board clock; it is the only clock.
REQ-004 Port rst, input, 1, is the reset: asynchronous, active-high.
REQ-005 Ports btn_next, btn_prev and btn_half are each input, 1, a raw asynchronous push-button level.
REQ-006 Port mem_addr, output, ADDR_W, is the word address presented to instruction memory.
REQ-007 Port mem_req, output, 1, is the read strobe to instruction memory.
REQ-008 Port mem_rdata, input, 32, is the memory read data.
REQ-009 Port mem_valid, input, 1, qualifies mem_rdata.
REQ-010 Port instruction, output, 32, is the held instruction word for the seven-segment display stage.
REQ-011 Port lower_bytes, output, 1, selects the displayed half: 1 = bits 15:0, 0 = bits 31:16.
REQ-012 Port pc, output, ADDR_W, is the current word address.
REQ-013 Port busy, output, 1, is high whenever the FSM is not in IDLE.

Function
REQ-014 Each button input shall pass through a 2-flop synchroniser, then a debouncer whose counter restarts on any change and updates the debounced level only after DEBOUNCE_CYCLES consecutive stable cycles.
REQ-015 A rising edge of a debounced level shall produce exactly one single-cycle pulse, no more than DEBOUNCE_CYCLES+3 cycles after the raw input settles high.
REQ-016 The FSM shall have the states START, REQ, WAIT and IDLE; the transitions are START->REQ unconditionally, REQ->WAIT after one cycle, WAIT->IDLE on mem_valid, and IDLE->REQ on an accepted step.
REQ-017 mem_req shall be 1 only in REQ, which lasts exactly one cycle, and mem_addr shall equal pc while in REQ and WAIT.
REQ-018 In WAIT, mem_valid=1 shall load instruction from mem_rdata and clear lower_bytes in the same edge.
REQ-019 mem_valid in any state other than WAIT shall be ignored.
REQ-020 In IDLE, a next pulse shall set pc to pc+1, wrapping 2^ADDR_W-1 to 0, and enter REQ.
REQ-021 In IDLE, a prev pulse shall set pc to pc-1, wrapping 0 to 2^ADDR_W-1, and enter REQ.
REQ-022 Next and prev pulses arriving in the same cycle shall both be discarded, with no state change.
REQ-023 Next and prev pulses arriving while busy=1 shall be discarded, not queued.
REQ-024 A half pulse in IDLE shall toggle lower_bytes.
REQ-025 A half pulse while busy=1 shall be discarded.
REQ-026 A half pulse in the same cycle as a next or prev step shall be discarded; the step wins.
REQ-027 instruction shall hold its value from capture until the next capture, including during REQ and WAIT.

Reset
REQ-028 While rst=1, pc shall be 0, instruction 0x00000000, lower_bytes 0, mem_req 0, busy 1, FSM in START, and all synchronisers, debouncers and edge detectors cleared.
REQ-029 The first cycle after rst deasserts shall be REQ with mem_addr=0, so address 0 is fetched without a button press.
REQ-030 Reset during REQ or WAIT shall abandon the fetch, and a late mem_valid shall be ignored until the next WAIT.

Configuration
REQ-031 With macro INSTRUCTION_STEPPER_AUTO_STEP_EN defined, the module shall add input auto_mode (1 bit) and parameter AUTO_PERIOD (default 100000000).
REQ-032 With that macro defined and auto_mode=1 in IDLE, a period counter reaching AUTO_PERIOD-1 shall perform a next step; the counter shall clear on any step, on auto_mode=0 and on reset.
REQ-033 Without the macro, neither auto_mode, AUTO_PERIOD nor the period counter shall exist, and behaviour is manual-only.

Verification (DEBOUNCE_CYCLES=4, ADDR_W=4, memory returns mem_valid 2 cycles after mem_req with data 0xA0000000+addr)
REQ-034 Bench shall cover: release rst -> mem_req at cycle 1 with mem_addr=0, then instruction=0xA0000000, lower_bytes=0, busy=0.
REQ-035 Bench shall cover: clean btn_next held 10 cycles, twice -> pc=2, instruction=0xA0000002; btn_prev from pc=0 -> pc=15, instruction=0xA000000F.
REQ-036 Bench shall cover: btn_next bouncing 1-0-1 at 2-cycle spacing, then stable -> exactly one step.
REQ-037 Bench shall cover: btn_half in IDLE -> lower_bytes toggles 0->1->0; btn_half during WAIT -> no change.
REQ-038 Bench shall cover: next and prev pulses forced in the same cycle -> pc unchanged, no mem_req; rst asserted during WAIT -> outputs at reset values, refetch of address 0 after release.
REQ-039 Bench shall cover, with INSTRUCTION_STEPPER_AUTO_STEP_EN defined, AUTO_PERIOD=8 and auto_mode=1: pc advances 0->1->2 with successive steps 8 idle cycles apart.

Source files
------------

// File: rtl/instruction_stepper.sv
// instruction_stepper: push-button single-stepper for an instruction memory.
// Three debounced buttons step the word address forward/back and pick which
// half of the fetched instruction word is shown on the display stage.
// Optional feature: define INSTRUCTION_STEPPER_AUTO_STEP_EN to add the
// auto_mode input and AUTO_PERIOD parameter for periodic automatic stepping.
module instruction_stepper #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ADDR_W          = 8
`ifdef INSTRUCTION_STEPPER_AUTO_STEP_EN
    ,
    parameter int unsigned AUTO_PERIOD     = 100000000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_half,
`ifdef INSTRUCTION_STEPPER_AUTO_STEP_EN
    input  logic              auto_mode,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [31:0]       instruction,
    output logic              lower_bytes,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {StStart, StReq, StWait, StIdle} state_t;

    // Bit 0 = next, bit 1 = prev, bit 2 = half.
    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       db_q, db_last_q;
    logic [CNT_W-1:0] db_cnt_q [3];
    logic [2:0]       pulse;

    state_t           state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]      instr_q;
    logic             lower_q;
    logic             mem_req_q;
    logic             busy_q;

    logic             idle;
    logic             auto_fire;
    logic             next_req;
    logic             do_next;
    logic             do_prev;
    logic             do_half;

    assign btn_raw = {btn_half, btn_prev, btn_next};

    // Two-flop synchronisers, debounce counters and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_last_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_last_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                // Any return to the accepted level restarts the stability count.
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign pulse = db_q & ~db_last_q;

    // Step decode: simultaneous next/prev cancel, and a step beats a half toggle.
    always_comb begin
        idle     = (state_q == StIdle);
        next_req = pulse[0] | auto_fire;
        do_next  = idle & next_req & ~pulse[1];
        do_prev  = idle & pulse[1] & ~next_req;
        do_half  = idle & pulse[2] & ~next_req & ~pulse[1];
    end

`ifdef INSTRUCTION_STEPPER_AUTO_STEP_EN
    localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    logic [AUTO_W-1:0] auto_cnt_q;

    assign auto_fire = idle & auto_mode & (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1));

    // Idle-time period counter for automatic next steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt_q <= '0;
        end else if (!auto_mode || do_next || do_prev || auto_fire) begin
            auto_cnt_q <= '0;
        end else if (idle) begin
            auto_cnt_q <= auto_cnt_q + AUTO_W'(1);
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    // Fetch FSM with registered strobe, busy flag and display state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StStart;
            pc_q      <= '0;
            instr_q   <= '0;
            lower_q   <= 1'b0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StStart: begin
                    state_q   <= StReq;
                    mem_req_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                StReq: begin
                    state_q   <= StWait;
                    mem_req_q <= 1'b0;
                end
                StWait: begin
                    if (mem_valid) begin
                        instr_q <= mem_rdata;
                        lower_q <= 1'b0;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StIdle: begin
                    if (do_next || do_prev) begin
                        pc_q      <= do_next ? pc_q + ADDR_W'(1) : pc_q - ADDR_W'(1);
                        state_q   <= StReq;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (do_half) begin
                        lower_q <= ~lower_q;
                    end
                end
                default: begin
                    state_q <= StStart;
                end
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign mem_req     = mem_req_q;
    assign instruction = instr_q;
    assign lower_bytes = lower_q;
    assign pc          = pc_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_instruction_stepper.sv
// Testbench for instruction_stepper: random button sequences checked against
// an address/display model, plus directed reset, bounce and conflict cases.
// Define INSTRUCTION_STEPPER_AUTO_STEP_EN to also exercise automatic stepping.
module tb_instruction_stepper;

    localparam int unsigned DB = 4;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_next = 1'b0;
    logic          btn_prev = 1'b0;
    logic          btn_half = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic [31:0]   mem_rdata = '0;
    logic          mem_valid = 1'b0;
    logic [31:0]   instruction;
    logic          lower_bytes;
    logic [AW-1:0] pc;
    logic          busy;
`ifdef INSTRUCTION_STEPPER_AUTO_STEP_EN
    logic          auto_mode = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Monitor/memory state.
    int          req_cnt = 0;
    int          idle_run = 0;
    int          last_idle_run = 0;
    logic        d1 = 1'b0, d2 = 1'b0;
    logic [31:0] data1 = '0, data2 = '0;

    // Reference model.
    int unsigned m_pc = 0;
    logic        m_lower = 1'b0;

    instruction_stepper #(
        .DEBOUNCE_CYCLES(DB),
        .ADDR_W         (AW)
`ifdef INSTRUCTION_STEPPER_AUTO_STEP_EN
        ,
        .AUTO_PERIOD    (8)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .btn_half   (btn_half),
`ifdef INSTRUCTION_STEPPER_AUTO_STEP_EN
        .auto_mode  (auto_mode),
`endif
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .instruction(instruction),
        .lower_bytes(lower_bytes),
        .pc         (pc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Memory answers two cycles after a request; also counts requests and idle runs.
    always @(negedge clk) begin
        mem_valid = d2;
        mem_rdata = data2;
        d2        = d1;
        data2     = data1;
        d1        = mem_req;
        data1     = 32'hA000_0000 + 32'(mem_addr);
        if (rst) begin
            idle_run = 0;
        end else if (mem_req) begin
            req_cnt       = req_cnt + 1;
            last_idle_run = idle_run;
            idle_run      = 0;
        end else if (!busy) begin
            idle_run = idle_run + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) tick(1);
        check("idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 60 && !mem_req; i++) tick(1);
        check("req_seen", 32'(mem_req), 32'd1);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"}, 32'(pc), m_pc);
        check({tag, "_instr"}, instruction, 32'hA000_0000 + m_pc);
        check({tag, "_lower"}, 32'(lower_bytes), 32'(m_lower));
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        {btn_half, btn_prev, btn_next} = mask;
        tick(hold);
        {btn_half, btn_prev, btn_next} = 3'b000;
        tick(12);
    endtask

    // op: 0 = next, 1 = prev, 2 = half.
    task automatic do_op(input int op, input int hold, input string tag);
        int r0;
        r0 = req_cnt;
        press(3'(1 << op), hold);
        wait_idle();
        case (op)
            0: begin m_pc = (m_pc + 1) % 16; m_lower = 1'b0; end
            1: begin m_pc = (m_pc + 15) % 16; m_lower = 1'b0; end
            default: m_lower = ~m_lower;
        endcase
        check_state(tag);
        check({tag, "_reqs"}, 32'(req_cnt - r0), (op == 2) ? 32'd0 : 32'd1);
    endtask

    initial begin
        int r0;
        int op;

        // Reset values while rst is held.
        tick(3);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_lower", 32'(lower_bytes), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // First cycle after release fetches address 0.
        rst = 1'b0;
        tick(1);
        check("boot_req", 32'(mem_req), 32'd1);
        check("boot_addr", 32'(mem_addr), 32'd0);
        wait_idle();
        check_state("boot");

        do_op(0, 10, "next1");
        do_op(0, 10, "next2");
        do_op(1, 10, "prev1");
        do_op(1, 10, "prev2");
        do_op(1, 10, "prev_wrap");

        // Bouncing press must produce exactly one step.
        r0 = req_cnt;
        btn_next = 1'b1; tick(2);
        btn_next = 1'b0; tick(2);
        btn_next = 1'b1; tick(10);
        btn_next = 1'b0; tick(12);
        wait_idle();
        m_pc = (m_pc + 1) % 16;
        check_state("bounce");
        check("bounce_reqs", 32'(req_cnt - r0), 32'd1);

        do_op(2, 10, "half_on");
        do_op(2, 10, "half_off");

        // Half pulse lands while the fetch is still outstanding.
        btn_next = 1'b1; tick(2);
        btn_half = 1'b1; tick(10);
        btn_next = 1'b0; btn_half = 1'b0; tick(12);
        wait_idle();
        m_pc = (m_pc + 1) % 16;
        m_lower = 1'b0;
        check_state("half_busy");

        // Simultaneous next and prev cancel.
        r0 = req_cnt;
        press(3'b011, 10);
        check_state("both");
        check("both_reqs", 32'(req_cnt - r0), 32'd0);

        // Random button sequence.
        for (int i = 0; i < 16; i++) begin
            op = int'($urandom_range(0, 2));
            do_op(op, int'($urandom_range(6, 12)), "rand");
        end

        // Reset during WAIT abandons the fetch and refetches address 0.
        btn_next = 1'b1;
        wait_req();
        tick(1);
        rst = 1'b1;
        btn_next = 1'b0;
        #1;
        check("wrst_pc", 32'(pc), 32'd0);
        check("wrst_instr", instruction, 32'd0);
        check("wrst_lower", 32'(lower_bytes), 32'd0);
        check("wrst_req", 32'(mem_req), 32'd0);
        check("wrst_busy", 32'(busy), 32'd1);
        tick(3);
        rst = 1'b0;
        tick(1);
        check("wrst_boot_req", 32'(mem_req), 32'd1);
        check("wrst_boot_addr", 32'(mem_addr), 32'd0);
        wait_idle();
        m_pc = 0;
        m_lower = 1'b0;
        check_state("wrst");

`ifdef INSTRUCTION_STEPPER_AUTO_STEP_EN
        // Automatic stepping every 8 idle cycles.
        rst = 1'b1;
        auto_mode = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        m_pc = 0;
        m_lower = 1'b0;
        wait_idle();
        check_state("auto0");
        for (int k = 0; k < 2; k++) begin
            wait_req();
            check("auto_gap", 32'(last_idle_run), 32'd8);
            wait_idle();
            m_pc = (m_pc + 1) % 16;
            check_state("auto");
        end
        auto_mode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
